// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target: state encoding, field widths and default address.
// The master bench imports the same package so both sides agree on the address.
package i2c_slave_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;
  localparam logic [ADDR_W-1:0] DEFAULT_SLAVE_ADDR = 7'h39;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_MACK,
    WAIT_STOP
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises scl/sda into the clk domain and derives SCL edges and START/STOP events.
// Every flop presets to 1 so that reset release never produces a false edge on an idle bus.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_lvl,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic                   scl_q;
  logic                   sda_q;
  logic                   scl_s;
  logic                   sda_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_q  <= 1'b1;
      sda_q  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda};
      scl_q  <= scl_s;
      sda_q  <= sda_s;
    end
  end

  assign scl_s     = scl_ff[SYNC_STAGES-1];
  assign sda_s     = sda_ff[SYNC_STAGES-1];
  assign sda_lvl   = sda_s;
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & sda_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: ACKs SLAVE_ADDR, hands written bytes to local logic and shifts read bytes out.
// sda is open-drain: the block only pulls it low or releases it.
module i2c_slave
  import i2c_slave_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_req,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              busy,
  output logic              rw
);

  state_t            state, state_n;
  logic [2:0]        cnt, cnt_n;
  logic [BYTE_W-1:0] sh, sh_n;
  logic              ack_low, ack_low_n;
  logic              acked, acked_n;
  logic [BYTE_W-1:0] rx_data_n;
  logic              rx_valid_n, tx_req_n, busy_n, rw_n;
  logic              scl_rise, scl_fall, sda_lvl, start_det, stop_det;
  logic              sda_oe;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_lvl   (sda_lvl),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  // Drive is decoded from state so an async reset releases the bus in the same cycle.
  assign sda_oe = ((state == ADDR_ACK || state == WR_ACK) && ack_low) ||
                  (state == RD_DATA && !sh[BYTE_W-1]);
  assign sda    = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd7;
      sh       <= '0;
      ack_low  <= 1'b0;
      acked    <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      rw       <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      ack_low  <= ack_low_n;
      acked    <= acked_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
      rw       <= rw_n;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    ack_low_n  = ack_low;
    acked_n    = acked;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;
    rw_n       = rw;

    if (start_det) begin
      state_n   = ADDR;
      cnt_n     = 3'd7;
      ack_low_n = 1'b0;
      acked_n   = 1'b0;
      busy_n    = 1'b1;
    end else if (stop_det) begin
      state_n   = IDLE;
      ack_low_n = 1'b0;
      acked_n   = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_n  = {sh[BYTE_W-2:0], sda_lvl};
          cnt_n = cnt - 3'd1;
          if (cnt == 3'd0) begin
            if (sh[BYTE_W-2:0] == SLAVE_ADDR) begin
              rw_n    = sda_lvl;
              state_n = ADDR_ACK;
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          // First fall starts the ACK slot, second fall closes it.
          if (scl_fall) begin
            if (!ack_low) begin
              ack_low_n = 1'b1;
            end else begin
              ack_low_n = 1'b0;
              if (state == WR_ACK || !rw) begin
                state_n = WR_DATA;
              end else begin
                state_n = RD_DATA;
                sh_n    = tx_data;
              end
            end
          end else if (scl_rise && ack_low && state == ADDR_ACK && rw) begin
            tx_req_n = 1'b1;
          end
        end
        WR_DATA: if (scl_rise) begin
          sh_n  = {sh[BYTE_W-2:0], sda_lvl};
          cnt_n = cnt - 3'd1;
          if (cnt == 3'd0) begin
            rx_data_n  = {sh[BYTE_W-2:0], sda_lvl};
            rx_valid_n = 1'b1;
            state_n    = WR_ACK;
          end
        end
        RD_DATA: if (scl_fall) begin
          cnt_n = cnt - 3'd1;
          if (cnt == 3'd0) state_n = RD_MACK;
          else             sh_n    = {sh[BYTE_W-2:0], 1'b0};
        end
        RD_MACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              acked_n  = 1'b1;
              tx_req_n = 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end else if (scl_fall && acked) begin
            acked_n = 1'b0;
            sh_n    = tx_data;
            state_n = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bus-level master plus a transaction model that predicts ACKs,
// received bytes, read data and tx_req counts; directed scenarios followed by random traffic.
module tb_i2c_slave;
  import i2c_slave_pkg::*;

  localparam int         Q   = 4;       // clk cycles per quarter SCL period
  localparam logic [6:0] SLV = 7'h39;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       m_low = 1'b0;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy, rw;
  logic [7:0] tx_data = 8'h00;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] tx_q[$];
  logic [7:0] wq[$];
  logic [7:0] rq[$];
  int rx_pulses = 0, tx_req_pulses = 0, slave_low_cycles = 0, busy_low_cycles = 0;
  bit watch_busy = 1'b0;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl_m),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .busy     (busy),
    .rw       (rw)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process and local-logic responder, sampled on the inactive clk edge.
  initial forever begin
    @(negedge clk);
    if (rx_valid) begin
      rx_pulses++;
      if (exp_rx.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_unexpected: got 0x%0h, expected no byte", rx_data);
      end else begin
        check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
    end
    if (tx_req) begin
      tx_req_pulses++;
      if (tx_q.size() > 0) tx_data = tx_q.pop_front();
    end
    if (sda === 1'b0 && !m_low) slave_low_cycles++;
    if (watch_busy && !busy) busy_low_cycles++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic got);
    wait_q(1); m_low = ~b;
    wait_q(1); scl_m = 1'b1;
    wait_q(1); got = sda;
    wait_q(1); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic g;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], g);
    bit_xfer(1'b1, g);
    ack = ~g;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, g);
      b[i] = g;
    end
    bit_xfer(~mack, g);
  endtask

  task automatic start_cond();
    if (scl_m) begin
      m_low = 1'b0; wait_q(1);
      m_low = 1'b1; wait_q(2);
    end else begin
      m_low = 1'b0; wait_q(2);
      scl_m = 1'b1; wait_q(2);
      m_low = 1'b1; wait_q(2);
    end
    scl_m = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic stop_cond();
    m_low = 1'b1; wait_q(1);
    scl_m = 1'b1; wait_q(2);
    m_low = 1'b0; wait_q(4);
    check("busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic master_write(input logic [6:0] addr, input bit do_stop);
    logic ack;
    bit   hit = (addr == SLV);
    int   p0  = rx_pulses;
    start_cond();
    send_byte({addr, 1'b0}, ack);
    check("addr_ack_w", 32'(ack), 32'(hit));
    if (hit) check("rw_write", 32'(rw), 32'd0);
    foreach (wq[i]) begin
      if (hit) exp_rx.push_back(wq[i]);
      send_byte(wq[i], ack);
      check("data_ack", 32'(ack), 32'(hit));
    end
    check("rx_count", 32'(rx_pulses - p0), hit ? 32'(wq.size()) : 32'd0);
    if (do_stop) stop_cond();
  endtask

  task automatic master_read(input logic [6:0] addr, input bit do_stop);
    logic       ack;
    logic [7:0] got;
    bit         hit = (addr == SLV);
    int         t0  = tx_req_pulses;
    int         n   = rq.size();
    foreach (rq[i]) tx_q.push_back(rq[i]);
    start_cond();
    send_byte({addr, 1'b1}, ack);
    check("addr_ack_r", 32'(ack), 32'(hit));
    if (hit) begin
      check("rw_read", 32'(rw), 32'd1);
      for (int i = 0; i < n; i++) begin
        recv_byte(i < n - 1, got);
        check("rd_byte", 32'(got), 32'(rq[i]));
      end
      check("tx_req_count", 32'(tx_req_pulses - t0), 32'(n));
      repeat (2) @(negedge clk);
      check("sda_released_after_nack", 32'(sda), 32'd1);
    end
    tx_q.delete();
    if (do_stop) stop_cond();
  endtask

  initial begin
    int   p0, s0;
    logic ack, g;
    bit   open;

    repeat (5) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    rst = 1'b0;
    wait_q(4);

    // Plain write of two bytes.
    wq = '{8'hCA, 8'h35};
    master_write(SLV, 1'b1);
    check("wr_last_rx", 32'(rx_data), 32'h35);

    // Foreign address: never ACKed, parked until STOP.
    s0 = slave_low_cycles;
    wq = '{8'h55};
    master_write(7'h3A, 1'b0);
    check("nack_state", 32'(dut.state), 32'(WAIT_STOP));
    check("nack_no_drive", 32'(slave_low_cycles - s0), 32'd0);
    stop_cond();

    // Read two bytes, ACK then NACK.
    rq = '{8'hA5, 8'h3C};
    master_read(SLV, 1'b1);

    // Write then repeated START into a read; busy must not drop.
    wq = '{8'hCA};
    master_write(SLV, 1'b0);
    check("rs_rx_data", 32'(rx_data), 32'hCA);
    busy_low_cycles = 0;
    watch_busy = 1'b1;
    rq = '{8'h0F};
    master_read(SLV, 1'b0);
    watch_busy = 1'b0;
    check("rs_busy_held", 32'(busy_low_cycles), 32'd0);
    check("rs_rw", 32'(rw), 32'd1);
    stop_cond();

    // Reset while the slave pulls a 0 data bit.
    tx_q.push_back(8'h5A);
    start_cond();
    send_byte(8'h73, ack);
    check("mid_rst_addr_ack", 32'(ack), 32'd1);
    wait_q(2);
    check("mid_rst_bit7_low", 32'(sda), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_sda_released", 32'(sda), 32'd1);
    check("mid_rst_rx_data", 32'(rx_data), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_tx_req", 32'(tx_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rw", 32'(rw), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    stop_cond();
    wq = '{8'h11};
    master_write(SLV, 1'b1);
    check("post_rst_rx", 32'(rx_data), 32'h11);

    // STOP after four address bits.
    s0 = slave_low_cycles;
    p0 = rx_pulses;
    start_cond();
    for (int i = 7; i >= 4; i--) bit_xfer(1'(8'h72 >> i), g);
    stop_cond();
    check("early_stop_state", 32'(dut.state), 32'(IDLE));
    check("early_stop_no_ack", 32'(slave_low_cycles - s0), 32'd0);
    check("early_stop_no_rx", 32'(rx_pulses - p0), 32'd0);

    // Random traffic against the transaction model.
    open = 1'b0;
    for (int it = 0; it < 24; it++) begin
      logic [6:0] addr;
      int         nb;
      bit         do_stop;
      addr    = ($urandom_range(0, 2) != 0) ? SLV : 7'($urandom);
      nb      = $urandom_range(1, 4);
      do_stop = ($urandom_range(0, 3) != 0);
      wq.delete();
      rq.delete();
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < nb; k++) wq.push_back(8'($urandom));
        master_write(addr, do_stop);
      end else begin
        for (int k = 0; k < nb; k++) rq.push_back(8'($urandom));
        master_read(addr, do_stop);
      end
      open = !do_stop;
    end
    if (open) stop_cond();

    wait_q(2);
    check("rx_leftover", 32'(exp_rx.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C responder (target) for the team's I2C master. Single 7-bit address, standard-mode protocol.
- Oversamples `scl` and `sda` on the system clock, detects START and STOP, and ACKs its own address.
- On a write transaction, delivers received bytes to local logic. On a read transaction, fetches bytes from local logic and shifts them onto `sda`.
- Open-drain behaviour: the block only ever drives `sda` low or releases it to Z.

Parameters:
- SLAVE_ADDR, 7'h39, 7-bit address the block ACKs.
- SYNC_STAGES, 2, flip-flop stages in the `scl`/`sda` input synchronisers. Legal values: 2..3.

Ports:
- clk  input  1  system clock; must be at least 8x the `scl` frequency.
- rst  input  1  asynchronous active-high reset.
- scl  input  1  I2C clock from the master.
- sda  inout  1  I2C data; driven 0 or Z only.
- rx_data  output  8  last byte received from the master.
- rx_valid  output  1  one-clk pulse; `rx_data` is valid in that cycle.
- tx_req  output  1  one-clk pulse; local logic must present the next read byte.
- tx_data  input  8  byte to send to the master; captured as defined below.
- busy  output  1  high from START until STOP.
- rw  output  1  R/W bit of the current transaction; 1 = master reads.

Behaviour:
- Reset (asynchronous, `rst`=1):
  - state=IDLE, `sda` released (Z).
  - rx_data=0, rx_valid=0, tx_req=0, busy=0, rw=0.
  - Synchronisers preset to 1.
- Input conditioning:
  - `scl` and `sda` pass through SYNC_STAGES flops; sda=Z is read as 1.
  - scl_rise/scl_fall = synced `scl` edge. Input latency is SYNC_STAGES+1 clk.
- START: synced `sda` 1->0 while synced `scl`=1. Recognised in any state, including mid-byte (repeated START). Action: go to ADDR, bit counter=7, release `sda`, busy=1.
- STOP: synced `sda` 0->1 while `scl`=1. Recognised in any state. Action: go to IDLE, release `sda`, busy=0.
- If START and STOP conditions land in the same cycle, START wins.
- Bit order is MSB first. `sda` is sampled on scl_rise. The block changes its own `sda` drive only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. After bit 0 (R/W) is sampled:
    - address == SLAVE_ADDR: latch `rw`, go to ADDR_ACK.
    - otherwise: go to WAIT_STOP and never drive `sda`.
  - ADDR_ACK:
    - Drive `sda`=0 from the next scl_fall through the following scl_fall.
    - If rw=1, pulse tx_req on the scl_rise of the ACK slot.
    - At the closing scl_fall, go to WR_DATA (rw=0) or RD_DATA (rw=1).
  - WR_DATA: shift 8 bits.
    - The cycle after the 8th scl_rise: rx_data updates and rx_valid pulses for 1 clk.
    - Then go to WR_ACK.
  - WR_ACK: drive ACK exactly as in ADDR_ACK, then return to WR_DATA. Writes are unbounded and always ACKed.
  - RD_DATA:
    - At entry, on the scl_fall, capture `tx_data` into the shift register and drive bit 7.
    - On each subsequent scl_fall, drive the next bit: 0 pulls `sda` low, 1 releases it.
    - After the 8th bit's scl_fall, release `sda` and go to RD_MACK.
  - RD_MACK: sample `sda` on scl_rise.
    - 0 (master ACK): pulse tx_req, go to RD_DATA at the next scl_fall.
    - 1 (master NACK): go to WAIT_STOP.
  - WAIT_STOP: `sda` released; wait for STOP or START.
- tx_req timing: local logic has from the tx_req pulse until the next scl_fall (at least 4 clk at the minimum clk ratio) to settle `tx_data`.
- Bit counter: 3 bits, counts 7 down to 0. When a byte completes, the counter wraps to 7.
- Reset mid-transaction: `sda` is released within the same cycle (combinational from state). After reset, the block ignores the bus until the next START.
- The block never stretches `scl` and has no `scl` output.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, WAIT_STOP;
  - ADDR_W=7 and BYTE_W=8;
  - default SLAVE_ADDR 7'h39, so master and slave benches agree.
- One sub-module: `i2c_bus_sync`. It contains the SYNC_STAGES synchronisers and outputs scl_rise, scl_fall, start_det, stop_det. The FSM and shift register stay in `i2c_slave`.

Test Plan:
- Write 0x72 (address 0x39, W), then 0xCA, 0x35, then STOP:
  - ACK driven low in all three ACK slots;
  - rx_valid pulses twice, rx_data=0xCA then 0x35;
  - busy returns to 0 after STOP.
- Address 0x3A, W, byte 0x55:
  - `sda` never driven low (NACK);
  - rx_valid never pulses;
  - state stays WAIT_STOP until STOP.
- Read 0x73 with tx_data=0xA5 then 0x3C; master ACKs the first byte and NACKs the second:
  - bus carries 10100101 then 00111100;
  - tx_req pulses exactly twice;
  - `sda` released after the NACK.
- Repeated START: write 0xCA, then START, 0x73 read, tx_data=0x0F:
  - rx_data=0xCA;
  - rw switches to 1;
  - 0x0F is returned;
  - busy stays 1 throughout.
- Assert `rst` while the slave drives a 0 data bit during a read:
  - `sda` is Z in the same cycle and all outputs go to reset values;
  - a following write 0x72/0x11 is ACKed with rx_data=0x11.
- STOP injected after 4 address bits: state goes to IDLE, no ACK, busy=0.
